batch_nml_op_issuer: RTL and testbench
======================================

Name: batch_nml_op_issuer

Overview:
- Operand issuer that sits upstream of batch_nml_mac_cell and drives its mac_cell_i_* input interface.
- Holds per-channel batch-norm parameters A/B in a small register file and precomputes the flags is_a_eq_1/is_b_eq_0 when each parameter is written.
- Consumes a ready/valid feature stream and issues one MAC operation (A[c], x, B[c]) per accepted feature, tracking element and channel position.
- Tags each issued operation with channel-last and frame-last info for downstream writeback.

Parameters:
- MAX_CHN_N, 64, depth of the parameter register file (maximum number of channels); power of two.
- SIM_DELAY, 1, simulation delay applied to register updates.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- aclken  in  1  clock enable; when low, all state holds
- bn_calfmt  in  2  format: 00 INT16, 01 INT32, 10 FP32
- fixed_point_quat_accrc  in  5  fixed-point fraction bits (integer formats only)
- ftm_sz  in  16  elements per channel minus 1
- chn_n  in  16  channels minus 1; must be < MAX_CHN_N
- param_wen  in  1  parameter write strobe
- param_waddr  in  log2(MAX_CHN_N)  channel index to write
- param_wdata_a  in  32  parameter A
- param_wdata_b  in  32  parameter B
- start  in  1  start-frame pulse
- busy  out  1  high from RUN entry until DONE
- done  out  1  one-cycle pulse at end of frame
- frame_err  out  1  sticky flag: s_ftm_last mismatch; cleared by start
- s_ftm_data  in  32  feature x
- s_ftm_last  in  1  producer's end-of-frame marker
- s_ftm_valid  in  1  feature valid
- s_ftm_ready  out  1  feature ready
- mac_cell_i_op_a  out  32  operand A
- mac_cell_i_op_x  out  32  operand X
- mac_cell_i_op_b  out  32  operand B
- mac_cell_i_is_a_eq_1  out  1  A equals 1.0 in the current format
- mac_cell_i_is_b_eq_0  out  1  B equals 0
- mac_cell_i_info_along  out  2  {frame_last, chn_last}
- mac_cell_i_vld  out  1  operation valid

Behaviour:
- Reset: state IDLE; counters 0; busy, done, frame_err, s_ftm_ready, and mac_cell_i_vld are 0; all other outputs are 0. Register-file contents are not reset.
- Parameter write (IDLE only, param_wen=1, aclken=1): store A, B and the two flags at param_waddr. param_wen in RUN or DONE is ignored.
  - is_a_eq_1: for FP32, A==32'h3F800000; for integer formats, A==(1<<fixed_point_quat_accrc).
  - is_b_eq_0: for FP32, B==32'h00000000 or 32'h80000000; for integer formats, B==0.
  - Flags use the bn_calfmt and fixed_point_quat_accrc values present at write time.
- FSM:
  - IDLE: on start, go to RUN, clear counters, clear frame_err.
  - RUN: s_ftm_ready=1. Each handshake (valid & ready & aclken) is one accept.
  - On the accept where elem_cnt==ftm_sz and chn_cnt==chn_n, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
  - start is ignored outside IDLE.
- Counters:
  - elem_cnt increments on each accept. At ftm_sz it wraps to 0 and chn_cnt increments.
  - chn_cnt wraps to 0 on frame end.
- Issue: registered, one-cycle latency. On each accept, the next edge loads:
  - op_x = s_ftm_data
  - op_a, op_b, and the flags from the register file at chn_cnt (combinational read)
  - info_along = {frame_last, chn_last} for this element
  - mac_cell_i_vld = 1
- Cycles without an accept load vld=0; data fields hold.
- There is no backpressure from the MAC cell; full-rate back-to-back issue is required.
- frame_err is set when either:
  - s_ftm_last=1 is accepted on a non-final element, or
  - s_ftm_last=0 is accepted on the final element.
  - The frame still completes by count.
- aclken=0 freezes all registers including vld, and s_ftm_ready=0.
- Reset mid-frame: immediately IDLE, vld=0, in-flight element dropped.
- Degenerate sizes: ftm_sz=0 makes every element chn_last; ftm_sz=0 with chn_n=0 gives a one-element frame (RUN→DONE on the first accept).

Decomposition:
- Shared package bn_pkg:
  - BN_CAL_FMT_INT16/INT32/FP32 encodings
  - FP32_ONE=32'h3F800000
  - FP32_NEG_ZERO=32'h80000000
  - FSM state enum {IDLE, RUN, DONE}
- One natural sub-module, bn_param_regfile: MAX_CHN_N×(32+32+2) storage with a synchronous write port and an asynchronous read port; flag computation stays in the parent.

Test Plan:
- FP32: write ch0 A=0x3F800000, B=0x42BB199A; ch1 A=0x3F333333, B=0x80000000. ftm_sz=1, chn_n=1; stream 4 features back-to-back → issues 2,3,4,5 cycles after start with flags ch0 {1,0} and ch1 {0,1}; info_along 00,01,00,11; done 1 cycle after the last accept.
- INT32: quat_accrc=1; write A=2, B=0 → is_a_eq_1=1, is_b_eq_0=1. Same A with quat_accrc=2 → is_a_eq_1=0.
- Bubbles: valid toggling 1,0,1,0 → vld toggles with one-cycle lag; op_x holds during bubbles.
- Bad last: s_ftm_last=1 on element 2 of 4 → frame_err=1, frame still finishes after 4 accepts. Next start clears frame_err.
- aclken low for 3 cycles mid-frame → ready=0 and all outputs frozen; the sequence resumes identically.
- Reset asserted after 2 of 6 accepts → vld=0, busy=0 immediately; a new start with 6 features completes normally; param_wen during RUN leaves the register file unchanged.

Source files
------------

// File: rtl/bn_pkg.sv
// Shared encodings, constants and flag helpers for the batch-norm operand issuer.
package bn_pkg;

    localparam logic [1:0] BN_CAL_FMT_INT16 = 2'b00;
    localparam logic [1:0] BN_CAL_FMT_INT32 = 2'b01;
    localparam logic [1:0] BN_CAL_FMT_FP32  = 2'b10;

    localparam logic [31:0] FP32_ONE      = 32'h3F80_0000;
    localparam logic [31:0] FP32_NEG_ZERO = 32'h8000_0000;

    typedef enum logic [1:0] {IDLE, RUN, DONE} bn_state_e;

    function automatic logic calc_is_a_eq_1(input logic [1:0]  fmt,
                                            input logic [4:0]  accrc,
                                            input logic [31:0] a);
        if (fmt == BN_CAL_FMT_FP32) begin
            return a == FP32_ONE;
        end
        return a == (32'd1 << accrc);
    endfunction

    // Both signed zeros count as zero in FP32.
    function automatic logic calc_is_b_eq_0(input logic [1:0]  fmt,
                                            input logic [31:0] b);
        if (fmt == BN_CAL_FMT_FP32) begin
            return (b == 32'd0) || (b == FP32_NEG_ZERO);
        end
        return b == 32'd0;
    endfunction

endpackage

// File: rtl/bn_param_regfile.sv
// Per-channel A/B parameter storage with precomputed flags.
// Synchronous write port, asynchronous read port, no reset on the contents.
module bn_param_regfile #(
    parameter int unsigned MAX_CHN_N = 64,
    parameter int unsigned ADDR_W    = $clog2(MAX_CHN_N)
) (
    input  logic              clk,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata_a,
    input  logic [31:0]       wdata_b,
    input  logic              wdata_a_eq_1,
    input  logic              wdata_b_eq_0,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata_a,
    output logic [31:0]       rdata_b,
    output logic              rdata_a_eq_1,
    output logic              rdata_b_eq_0
);

    logic [65:0] mem [MAX_CHN_N];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= {wdata_a, wdata_b, wdata_a_eq_1, wdata_b_eq_0};
        end
    end

    assign {rdata_a, rdata_b, rdata_a_eq_1, rdata_b_eq_0} = mem[raddr];

endmodule

// File: rtl/batch_nml_op_issuer.sv
// Issues one (A[c], x, B[c]) MAC operation per accepted feature, tagging each
// with channel-last / frame-last, and checks the producer's end-of-frame marker.
module batch_nml_op_issuer
    import bn_pkg::*;
#(
    parameter int unsigned MAX_CHN_N = 64,
    parameter int unsigned SIM_DELAY = 1
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         aclken,
    input  logic [1:0]                   bn_calfmt,
    input  logic [4:0]                   fixed_point_quat_accrc,
    input  logic [15:0]                  ftm_sz,
    input  logic [15:0]                  chn_n,
    input  logic                         param_wen,
    input  logic [$clog2(MAX_CHN_N)-1:0] param_waddr,
    input  logic [31:0]                  param_wdata_a,
    input  logic [31:0]                  param_wdata_b,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         frame_err,
    input  logic [31:0]                  s_ftm_data,
    input  logic                         s_ftm_last,
    input  logic                         s_ftm_valid,
    output logic                         s_ftm_ready,
    output logic [31:0]                  mac_cell_i_op_a,
    output logic [31:0]                  mac_cell_i_op_x,
    output logic [31:0]                  mac_cell_i_op_b,
    output logic                         mac_cell_i_is_a_eq_1,
    output logic                         mac_cell_i_is_b_eq_0,
    output logic [1:0]                   mac_cell_i_info_along,
    output logic                         mac_cell_i_vld
);

    localparam int unsigned AW = $clog2(MAX_CHN_N);

    // Register updates carry no modelled delay; SIM_DELAY is accepted so that
    // existing instantiations keep elaborating.
    if (SIM_DELAY > 32'd0) begin : g_sim_delay_unmodelled
    end

    bn_state_e   state;
    logic [15:0] elem_cnt;
    logic [15:0] chn_cnt;

    logic        accept;
    logic        elem_last;
    logic        frame_last;
    logic        param_we;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic        rd_a_eq_1;
    logic        rd_b_eq_0;

    assign s_ftm_ready = aclken && (state == RUN);
    assign accept      = s_ftm_valid && s_ftm_ready;
    assign elem_last   = (elem_cnt == ftm_sz);
    assign frame_last  = elem_last && (chn_cnt == chn_n);
    assign param_we    = aclken && param_wen && (state == IDLE);

    bn_param_regfile #(
        .MAX_CHN_N (MAX_CHN_N),
        .ADDR_W    (AW)
    ) u_regfile (
        .clk          (aclk),
        .wen          (param_we),
        .waddr        (param_waddr),
        .wdata_a      (param_wdata_a),
        .wdata_b      (param_wdata_b),
        .wdata_a_eq_1 (calc_is_a_eq_1(bn_calfmt, fixed_point_quat_accrc, param_wdata_a)),
        .wdata_b_eq_0 (calc_is_b_eq_0(bn_calfmt, param_wdata_b)),
        .raddr        (chn_cnt[AW-1:0]),
        .rdata_a      (rd_a),
        .rdata_b      (rd_b),
        .rdata_a_eq_1 (rd_a_eq_1),
        .rdata_b_eq_0 (rd_b_eq_0)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state                 <= IDLE;
            elem_cnt              <= 16'd0;
            chn_cnt               <= 16'd0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            frame_err             <= 1'b0;
            mac_cell_i_op_a       <= 32'd0;
            mac_cell_i_op_x       <= 32'd0;
            mac_cell_i_op_b       <= 32'd0;
            mac_cell_i_is_a_eq_1  <= 1'b0;
            mac_cell_i_is_b_eq_0  <= 1'b0;
            mac_cell_i_info_along <= 2'b00;
            mac_cell_i_vld        <= 1'b0;
        end else if (aclken) begin
            done           <= 1'b0;
            mac_cell_i_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        elem_cnt  <= 16'd0;
                        chn_cnt   <= 16'd0;
                        frame_err <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        mac_cell_i_vld        <= 1'b1;
                        mac_cell_i_op_x       <= s_ftm_data;
                        mac_cell_i_op_a       <= rd_a;
                        mac_cell_i_op_b       <= rd_b;
                        mac_cell_i_is_a_eq_1  <= rd_a_eq_1;
                        mac_cell_i_is_b_eq_0  <= rd_b_eq_0;
                        mac_cell_i_info_along <= {frame_last, elem_last};
                        // The frame always ends by count; a wrong marker is only flagged.
                        if (s_ftm_last != frame_last) begin
                            frame_err <= 1'b1;
                        end
                        if (elem_last) begin
                            elem_cnt <= 16'd0;
                            chn_cnt  <= frame_last ? 16'd0 : chn_cnt + 16'd1;
                        end else begin
                            elem_cnt <= elem_cnt + 16'd1;
                        end
                        if (frame_last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_batch_nml_op_issuer.sv
// Scoreboard bench for batch_nml_op_issuer: the driver pushes expected issues
// from a parameter model, a negedge monitor pops and compares them.
module tb_batch_nml_op_issuer;

    localparam int unsigned MAXC = 16;

    logic        aclk;
    logic        aresetn;
    logic        aclken;
    logic [1:0]  bn_calfmt;
    logic [4:0]  fixed_point_quat_accrc;
    logic [15:0] ftm_sz;
    logic [15:0] chn_n;
    logic        param_wen;
    logic [3:0]  param_waddr;
    logic [31:0] param_wdata_a;
    logic [31:0] param_wdata_b;
    logic        start;
    logic        busy;
    logic        done;
    logic        frame_err;
    logic [31:0] s_ftm_data;
    logic        s_ftm_last;
    logic        s_ftm_valid;
    logic        s_ftm_ready;
    logic [31:0] op_a;
    logic [31:0] op_x;
    logic [31:0] op_b;
    logic        is_a_eq_1;
    logic        is_b_eq_0;
    logic [1:0]  info_along;
    logic        vld;

    batch_nml_op_issuer #(
        .MAX_CHN_N (MAXC),
        .SIM_DELAY (1)
    ) dut (
        .aclk                   (aclk),
        .aresetn                (aresetn),
        .aclken                 (aclken),
        .bn_calfmt              (bn_calfmt),
        .fixed_point_quat_accrc (fixed_point_quat_accrc),
        .ftm_sz                 (ftm_sz),
        .chn_n                  (chn_n),
        .param_wen              (param_wen),
        .param_waddr            (param_waddr),
        .param_wdata_a          (param_wdata_a),
        .param_wdata_b          (param_wdata_b),
        .start                  (start),
        .busy                   (busy),
        .done                   (done),
        .frame_err              (frame_err),
        .s_ftm_data             (s_ftm_data),
        .s_ftm_last             (s_ftm_last),
        .s_ftm_valid            (s_ftm_valid),
        .s_ftm_ready            (s_ftm_ready),
        .mac_cell_i_op_a        (op_a),
        .mac_cell_i_op_x        (op_x),
        .mac_cell_i_op_b        (op_b),
        .mac_cell_i_is_a_eq_1   (is_a_eq_1),
        .mac_cell_i_is_b_eq_0   (is_b_eq_0),
        .mac_cell_i_info_along  (info_along),
        .mac_cell_i_vld         (vld)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] x;
        logic [31:0] b;
        logic        fa;
        logic        fb;
        logic [1:0]  info;
        int          cyc;
    } item_t;

    item_t       q[$];
    item_t       last_item;
    bit          last_vld;
    logic [31:0] m_a [MAXC];
    logic [31:0] m_b [MAXC];
    logic        m_fa [MAXC];
    logic        m_fb [MAXC];

    int n_checks;
    int n_pass;
    int cyc;
    bit en_at_edge;
    bit mon_on;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [127:0] pack(input item_t it);
        return {28'd0, it.a, it.x, it.b, it.fa, it.fb, it.info};
    endfunction

    function automatic logic ref_a_one(input logic [1:0] fmt, input logic [4:0] acc,
                                       input logic [31:0] a);
        if (fmt == 2'b10) return a == 32'h3F80_0000;
        return a == (32'h1 << acc);
    endfunction

    function automatic logic ref_b_zero(input logic [1:0] fmt, input logic [31:0] b);
        if (fmt == 2'b10) return (b == 32'h0) || (b == 32'h8000_0000);
        return b == 32'h0;
    endfunction

    function automatic item_t zero_item();
        item_t it;
        it.a = 32'd0; it.x = 32'd0; it.b = 32'd0;
        it.fa = 1'b0; it.fb = 1'b0; it.info = 2'b00; it.cyc = 0;
        return it;
    endfunction

    always @(posedge aclk) begin
        cyc        <= cyc + 1;
        en_at_edge <= aclken;
    end

    // Monitor: an issue is expected exactly on the edge the driver scheduled it for.
    logic [127:0] mon_dut;
    bit           mon_ev;
    item_t        mon_it;
    always @(negedge aclk) begin
        if (aresetn && mon_on) begin
            mon_dut = {28'd0, op_a, op_x, op_b, is_a_eq_1, is_b_eq_0, info_along};
            if (en_at_edge) begin
                mon_ev = (q.size() > 0) && (q[0].cyc == cyc);
                chk("issue_vld", 128'(vld), 128'(mon_ev));
                if (mon_ev) begin
                    mon_it = q.pop_front();
                    chk("issue_data", mon_dut, pack(mon_it));
                    last_item = mon_it;
                end else begin
                    chk("hold_data", mon_dut, pack(last_item));
                end
                last_vld = mon_ev;
            end else begin
                chk("frozen_vld", 128'(vld), 128'(last_vld));
                chk("frozen_data", mon_dut, pack(last_item));
            end
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic write_param(input int ch, input logic [31:0] a, input logic [31:0] b);
        param_wen     = 1'b1;
        param_waddr   = 4'(ch);
        param_wdata_a = a;
        param_wdata_b = b;
        step();
        param_wen = 1'b0;
        m_a[ch]  = a;
        m_b[ch]  = b;
        m_fa[ch] = ref_a_one(bn_calfmt, fixed_point_quat_accrc, a);
        m_fb[ch] = ref_b_zero(bn_calfmt, b);
    endtask

    function automatic logic [31:0] pick_val(input int kind);
        case (kind)
            0: return 32'h3F80_0000;
            1: return 32'h1 << fixed_point_quat_accrc;
            2: return 32'h0;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // mode: 0 back-to-back, 1 alternating valid, 2 random valid and aclken.
    task automatic run_frame(input int ftm, input int chn, input int mode, input int freeze_at,
                             input int bad_idx, input int abort_after, input bit wen_junk);
        int    total;
        int    idx;
        int    guard;
        int    frz;
        bit    exp_err;
        bit    is_final;
        item_t it;
        total   = (ftm + 1) * (chn + 1);
        exp_err = 1'b0;
        ftm_sz  = 16'(ftm);
        chn_n   = 16'(chn);
        start   = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", 128'(busy), 128'(1));
        chk("frame_err_cleared", 128'(frame_err), 128'(0));
        idx   = 0;
        guard = 0;
        frz   = 0;
        while (idx < total && guard < 2000) begin
            if (idx == abort_after) break;
            guard++;
            aclken = 1'b1;
            if (freeze_at == idx && frz < 3) begin
                aclken = 1'b0;
                frz++;
            end
            if (mode == 2 && $urandom_range(0, 7) == 0) aclken = 1'b0;
            case (mode)
                0:       s_ftm_valid = 1'b1;
                1:       s_ftm_valid = (guard % 2 == 1);
                default: s_ftm_valid = ($urandom_range(0, 3) != 0);
            endcase
            is_final   = (idx == total - 1);
            s_ftm_data = $urandom;
            s_ftm_last = is_final ^ (idx == bad_idx);
            if (wen_junk) begin
                param_wen     = 1'b1;
                param_waddr   = 4'($urandom_range(0, MAXC - 1));
                param_wdata_a = $urandom;
                param_wdata_b = $urandom;
            end
            @(negedge aclk);
            chk("ready", 128'(s_ftm_ready), 128'(aclken));
            if (s_ftm_valid && aclken) begin
                it.a    = m_a[idx / (ftm + 1)];
                it.b    = m_b[idx / (ftm + 1)];
                it.fa   = m_fa[idx / (ftm + 1)];
                it.fb   = m_fb[idx / (ftm + 1)];
                it.x    = s_ftm_data;
                it.info = {is_final, (idx % (ftm + 1)) == ftm};
                it.cyc  = cyc + 1;
                q.push_back(it);
                if (s_ftm_last != is_final) exp_err = 1'b1;
                idx++;
            end
            step();
        end
        s_ftm_valid = 1'b0;
        s_ftm_last  = 1'b0;
        aclken      = 1'b1;
        param_wen   = 1'b0;
        if (abort_after >= 0) begin
            aresetn = 1'b0;
            #1;
            chk("reset_vld", 128'(vld), 128'(0));
            chk("reset_busy", 128'(busy), 128'(0));
            q.delete();
            last_item = zero_item();
            last_vld  = 1'b0;
            step();
            aresetn = 1'b1;
            return;
        end
        if (guard >= 2000) chk("frame_timeout", 128'(idx), 128'(total));
        chk("done_pulse", 128'(done), 128'(1));
        chk("busy_end", 128'(busy), 128'(0));
        chk("frame_err", 128'(frame_err), 128'(exp_err));
        step();
        chk("done_clears", 128'(done), 128'(0));
    endtask

    initial begin
        aresetn = 1'b1; aclken = 1'b1; bn_calfmt = 2'b10; fixed_point_quat_accrc = 5'd0;
        ftm_sz = 16'd0; chn_n = 16'd0; param_wen = 1'b0; param_waddr = 4'd0;
        param_wdata_a = 32'd0; param_wdata_b = 32'd0; start = 1'b0;
        s_ftm_data = 32'd0; s_ftm_last = 1'b0; s_ftm_valid = 1'b0;
        last_item = zero_item(); last_vld = 1'b0; mon_on = 1'b0;
        #2 aresetn = 1'b0;
        repeat (3) step();
        chk("reset_ctrl", 128'({busy, done, frame_err, s_ftm_ready, vld}), 128'(0));
        chk("reset_data", {28'd0, op_a, op_x, op_b, is_a_eq_1, is_b_eq_0, info_along}, 128'(0));
        aresetn = 1'b1;
        mon_on  = 1'b1;
        step();

        // FP32 two-channel frame, back-to-back.
        bn_calfmt = 2'b10;
        write_param(0, 32'h3F80_0000, 32'h42BB_199A);
        write_param(1, 32'h3F33_3333, 32'h8000_0000);
        run_frame(1, 1, 0, -1, -1, -1, 1'b0);

        // Integer flag rules with different fraction widths.
        bn_calfmt = 2'b01;
        fixed_point_quat_accrc = 5'd1;
        write_param(0, 32'd2, 32'd0);
        fixed_point_quat_accrc = 5'd2;
        write_param(1, 32'd2, 32'd0);
        bn_calfmt = 2'b00;
        fixed_point_quat_accrc = 5'd0;
        write_param(2, 32'd1, 32'd7);
        run_frame(0, 2, 0, -1, -1, -1, 1'b0);
        run_frame(0, 0, 0, -1, -1, -1, 1'b0);

        run_frame(1, 1, 1, -1, -1, -1, 1'b0);
        run_frame(1, 1, 0, -1, 1, -1, 1'b0);
        chk("frame_err_sticky", 128'(frame_err), 128'(1));
        run_frame(1, 1, 0, 2, -1, -1, 1'b0);

        run_frame(2, 1, 0, -1, -1, 2, 1'b0);
        step();
        run_frame(2, 1, 0, -1, -1, -1, 1'b1);
        run_frame(2, 1, 2, -1, -1, -1, 1'b0);

        for (int f = 0; f < 10; f++) begin
            int ftm;
            int chn;
            int bad;
            bn_calfmt = 2'($urandom_range(0, 2));
            fixed_point_quat_accrc = 5'($urandom_range(0, 20));
            ftm = $urandom_range(0, 3);
            chn = (f == 9) ? MAXC - 1 : $urandom_range(0, 5);
            for (int c = 0; c <= chn; c++) begin
                write_param(c, pick_val($urandom_range(0, 5)), pick_val($urandom_range(0, 5)));
            end
            bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (ftm + 1) * (chn + 1) - 1) : -1;
            run_frame(ftm, chn, 2, -1, bad, -1, 1'b0);
        end

        repeat (3) step();
        chk("queue_drained", 128'(q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
